// File: rtl/rx_sipo_check.sv
// rtl/rx_sipo_check.sv - rx serial-to-parallel frame capture with parity/framing/overrun checks
module rx_sipo_check #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       sample_done,
    input  logic       run_shift,
    input  logic       parity_load,
    input  logic       chk_stop,
    input  logic       rx_ack,
    output logic       parity_error,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       overrun_error
);

    logic [10:0] frame;
    logic [3:0]  bit_cnt;
    logic        perr_q;
    logic        perr;
    logic        shift_en;
    logic        good;
    logic        load;

    // Line bits enter at the top so the start bit ends up in frame[0] after 11 shifts.
    assign shift_en     = run_shift & sample_done & (bit_cnt < 4'd11);
    assign perr         = (^frame[9:1]) ^ PARITY_ODD;
    assign parity_error = parity_load & perr;
    assign good         = (bit_cnt == 4'd11) & ~frame[0] & frame[10] & ~perr_q;
    assign load         = chk_stop & good & (~rx_valid | rx_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame         <= 11'h7FF;
            bit_cnt       <= 4'd0;
            perr_q        <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            frame_error   <= chk_stop & ~good;
            overrun_error <= chk_stop & good & rx_valid & ~rx_ack;

            if (chk_stop) begin
                bit_cnt <= 4'd0;
            end else if (shift_en) begin
                frame   <= {rx_in, frame[10:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end else if (!run_shift && !parity_load) begin
                bit_cnt <= 4'd0;
            end

            if (parity_load) begin
                perr_q <= perr;
            end

            // A frame loading in the same cycle as an ack keeps rx_valid set.
            if (load) begin
                rx_data  <= frame[8:1];
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_sipo_check.sv
// tb/tb_rx_sipo_check.sv - directed self-checking bench for rx_sipo_check
module tb_rx_sipo_check;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic       sample_done;
    logic       run_shift;
    logic       parity_load;
    logic       chk_stop;
    logic       rx_ack;
    logic       parity_error;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun_error;

    int errors = 0;
    int checks = 0;
    logic pe;

    rx_sipo_check #(.PARITY_ODD(1'b0)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .sample_done   (sample_done),
        .run_shift     (run_shift),
        .parity_load   (parity_load),
        .chk_stop      (chk_stop),
        .rx_ack        (rx_ack),
        .parity_error  (parity_error),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives nbits shift strobes, a parity cycle, then optionally a stop cycle.
    // Returns at the negedge after the stop-check edge; pe_obs is parity_error seen in the parity cycle.
    task automatic run_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int nbits, input logic do_stop, input logic ack,
                             output logic pe_obs);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            rx_in       = (i < 11) ? bits[i] : 1'b0;
            run_shift   = 1'b1;
            sample_done = 1'b1;
        end
        @(negedge clk);
        run_shift   = 1'b0;
        sample_done = 1'b0;
        rx_in       = 1'b1;
        parity_load = 1'b1;
        #1 pe_obs = parity_error;
        @(negedge clk);
        parity_load = 1'b0;
        if (do_stop) begin
            chk_stop = 1'b1;
            rx_ack   = ack;
        end
        @(negedge clk);
        chk_stop = 1'b0;
        rx_ack   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; rx_in = 1'b1; sample_done = 1'b0; run_shift = 1'b0;
        parity_load = 1'b0; chk_stop = 1'b0; rx_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_ovr", overrun_error, 1'b0);
        check("rst_perr", parity_error, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // 1) good 0xA5, even parity
        run_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1, 1'b0, pe);
        check("t1_perr", pe, 1'b0);
        check("t1_valid", rx_valid, 1'b1);
        check("t1_data", rx_data, 8'hA5);
        check("t1_ferr", frame_error, 1'b0);
        @(negedge clk); rx_ack = 1'b1;
        @(negedge clk); rx_ack = 1'b0;
        check("t1_ack_clr", rx_valid, 1'b0);
        check("t1_data_hold", rx_data, 8'hA5);

        // 2) bad parity, FSM aborts without chk_stop
        run_frame(8'hA5, 1'b1, 1'b1, 11, 1'b0, 1'b0, pe);
        check("t2_perr", pe, 1'b1);
        check("t2_valid", rx_valid, 1'b0);
        check("t2_ferr", frame_error, 1'b0);
        check("t2_perr_idle", parity_error, 1'b0);

        // 3) bad stop bit
        run_frame(8'h3C, 1'b0, 1'b0, 11, 1'b1, 1'b0, pe);
        check("t3_perr", pe, 1'b0);
        check("t3_ferr", frame_error, 1'b1);
        check("t3_valid", rx_valid, 1'b0);
        @(negedge clk);
        check("t3_ferr_pulse", frame_error, 1'b0);

        // short frame: 10 strobes only
        run_frame(8'h3C, 1'b0, 1'b1, 10, 1'b1, 1'b0, pe);
        check("short_ferr", frame_error, 1'b1);
        check("short_valid", rx_valid, 1'b0);

        // 4) overrun
        run_frame(8'h11, 1'b0, 1'b1, 11, 1'b1, 1'b0, pe);
        check("t4a_data", rx_data, 8'h11);
        check("t4a_valid", rx_valid, 1'b1);
        run_frame(8'h22, 1'b0, 1'b1, 11, 1'b1, 1'b0, pe);
        check("t4_ovr", overrun_error, 1'b1);
        check("t4_data", rx_data, 8'h11);
        check("t4_valid", rx_valid, 1'b1);
        check("t4_ferr", frame_error, 1'b0);
        @(negedge clk);
        check("t4_ovr_pulse", overrun_error, 1'b0);

        // 5) ack coincident with chk_stop
        run_frame(8'h22, 1'b0, 1'b1, 11, 1'b1, 1'b1, pe);
        check("t5_data", rx_data, 8'h22);
        check("t5_valid", rx_valid, 1'b1);
        check("t5_ovr", overrun_error, 1'b0);

        // 6) reset after 5 shifts
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_in = i[0]; run_shift = 1'b1; sample_done = 1'b1;
        end
        #2 reset = 1'b0;
        run_shift = 1'b0; sample_done = 1'b0; rx_in = 1'b1;
        #1;
        check("t6_valid", rx_valid, 1'b0);
        check("t6_data", rx_data, 8'h00);
        check("t6_ferr", frame_error, 1'b0);
        check("t6_ovr", overrun_error, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        // 12 strobes: the one beyond the stop bit must be ignored
        run_frame(8'h5A, 1'b0, 1'b1, 12, 1'b1, 1'b0, pe);
        check("t6_perr", pe, 1'b0);
        check("t6_new_data", rx_data, 8'h5A);
        check("t6_new_valid", rx_valid, 1'b1);
        check("t6_new_ferr", frame_error, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
